// File: rtl/shared_delay_timer_arbiter_pkg.sv
// Shared types and helpers for the shared delay timer arbiter.
package shared_timer_pkg;

  // Timer ownership FSM states.
  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } t_timer_state;

  // Upper bound on requester count that the round-robin helper can search.
  localparam int RR_MAX_REQ = 32;

  // Returns the first set bit of req, starting at ptr and wrapping modulo
  // num_req. Requires ptr < num_req. Iterating from the far end means the
  // last hit written is the nearest one to ptr, so no early exit is needed.
  // The result is only meaningful when at least one bit of req is set.
  function automatic int rr_first_set(
    input logic [RR_MAX_REQ-1:0] req,
    input int                    num_req,
    input int                    ptr
  );
    int pick;
    int k;
    pick = 0;
    for (int i = RR_MAX_REQ - 1; i >= 0; i--) begin
      if (i < num_req) begin
        k = ptr + i;
        if (k >= num_req) begin
          k = k - num_req;
        end
        if (req[k[4:0]]) begin
          pick = k;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/shared_delay_timer_arbiter_if.sv
// Request/grant bundle between requesters and the shared delay timer.
interface shared_delay_timer_arbiter_if #(
  parameter int par_num_req   = 4,
  parameter int par_cnt_width = 16
);

  localparam int IDX_W = $clog2(par_num_req);

  logic [par_num_req-1:0]               i_req;
  logic [par_num_req*par_cnt_width-1:0] i_dly_ticks;
  logic [par_num_req-1:0]               o_gnt;
  logic [IDX_W-1:0]                     o_gnt_idx;
  logic [par_num_req-1:0]               o_done;
  logic                                 o_busy;

  // Requester side: raises requests and supplies delays.
  modport master (
    output i_req,
    output i_dly_ticks,
    input  o_gnt,
    input  o_gnt_idx,
    input  o_done,
    input  o_busy
  );

  // Timer side: arbitrates and reports grant/completion.
  modport slave (
    input  i_req,
    input  i_dly_ticks,
    output o_gnt,
    output o_gnt_idx,
    output o_done,
    output o_busy
  );

endinterface

// File: rtl/shared_delay_timer_arbiter_tick_prescaler.sv
// Free-running divide-by-N clock enable; counts only while i_run is high.
module tick_prescaler #(
  parameter int par_tick_divisor = 100
) (
  input  logic i_clk_mhz,
  input  logic i_rst_mhz_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_tick
);

  localparam int             PW   = $clog2(par_tick_divisor);
  localparam logic [PW-1:0]  LAST = PW'(par_tick_divisor - 1);

  logic [PW-1:0] cnt_reg;
  logic [PW-1:0] cnt_next;

  // Next count: synchronous clear wins, otherwise wrap at the last phase.
  always_comb begin
    cnt_next = cnt_reg;
    if (i_clear) begin
      cnt_next = '0;
    end else if (i_run) begin
      cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  // Prescaler phase register.
  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
    if (!i_rst_mhz_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign o_tick = i_run && (cnt_reg == LAST);

endmodule

// File: rtl/shared_delay_timer_arbiter.sv
// One prescaled countdown timer shared round-robin between requesters.
// The grantee's delay is latched at grant; completion is a one-cycle pulse.
module shared_delay_timer_arbiter
  import shared_timer_pkg::*;
#(
  parameter int par_num_req      = 4,
  parameter int par_cnt_width    = 16,
  parameter int par_tick_divisor = 100
) (
  input  logic                         i_clk_mhz,
  input  logic                         i_rst_mhz_n,
  shared_delay_timer_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(par_num_req);
  localparam int W     = par_cnt_width;

  t_timer_state     state_reg;
  t_timer_state     state_next;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] idx_next;
  logic [W-1:0]     cnt_reg;
  logic [W-1:0]     cnt_next;

  logic [W-1:0]           dly_arr [par_num_req];
  logic [RR_MAX_REQ-1:0]  req_ext;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       idx_inc;
  logic                   any_req;
  logic                   grant_now;
  logic                   tick;
  logic [par_num_req-1:0] gnt_vec;
  logic [par_num_req-1:0] done_vec;

  // Unpack the flattened delay bus and build the one-hot outputs per lane.
  generate
    for (genvar gi = 0; gi < par_num_req; gi++) begin : g_lane
      assign dly_arr[gi]  = bus.i_dly_ticks[gi*W +: W];
      assign gnt_vec[gi]  = (state_reg != S_IDLE) && (idx_reg == IDX_W'(gi));
      assign done_vec[gi] = (state_reg == S_DONE) && (idx_reg == IDX_W'(gi));
    end
  endgenerate

  assign req_ext   = RR_MAX_REQ'(bus.i_req);
  assign any_req   = |bus.i_req;
  assign win_idx   = IDX_W'(rr_first_set(req_ext, par_num_req, int'(ptr_reg)));
  assign idx_inc   = (idx_reg == IDX_W'(par_num_req - 1)) ? '0 : idx_reg + 1'b1;
  assign grant_now = (state_reg == S_IDLE) && any_req;

  tick_prescaler #(
    .par_tick_divisor (par_tick_divisor)
  ) u_prescaler (
    .i_clk_mhz   (i_clk_mhz),
    .i_rst_mhz_n (i_rst_mhz_n),
    .i_clear     (grant_now),
    .i_run       (state_reg == S_COUNT),
    .o_tick      (tick)
  );

  // Next-state logic: arbitration, countdown, cancel and release.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (any_req) begin
          idx_next   = win_idx;
          cnt_next   = dly_arr[win_idx];
          state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        // A dropped request beats a final tick landing in the same cycle.
        if (!bus.i_req[idx_reg]) begin
          state_next = S_IDLE;
          ptr_next   = idx_inc;
        end else if (cnt_reg == '0) begin
          state_next = S_DONE;
        end else if (tick) begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == W'(1)) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
        ptr_next   = idx_inc;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, round-robin pointer, grantee index and delay counter registers.
  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz_n) begin
    if (!i_rst_mhz_n) begin
      state_reg <= S_IDLE;
      ptr_reg   <= '0;
      idx_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.o_gnt     = gnt_vec;
  assign bus.o_done    = done_vec;
  assign bus.o_busy    = (state_reg != S_IDLE);
  assign bus.o_gnt_idx = idx_reg;

endmodule

// File: tb/tb_shared_delay_timer_arbiter.sv
// Randomized bench for shared_delay_timer_arbiter against a timeline model.
module tb_shared_delay_timer_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  shared_delay_timer_arbiter_if #(.par_num_req(N), .par_cnt_width(W)) bus_if ();

  shared_delay_timer_arbiter #(
    .par_num_req      (N),
    .par_cnt_width    (W),
    .par_tick_divisor (DIV)
  ) u_dut (
    .i_clk_mhz   (clk),
    .i_rst_mhz_n (rst_n),
    .bus         (bus_if)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: owner (-1 = none), cycles remaining until the done
  // cycle, round-robin pointer and last grantee.
  int m_owner = -1;
  int m_rem   = 0;
  int m_ptr   = 0;
  int m_idx   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rem   = 0;
    m_ptr   = 0;
    m_idx   = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_done;
    e_gnt  = '0;
    e_done = '0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      if (m_rem == 0) e_done[m_owner] = 1'b1;
    end
    check_val("gnt",  32'(bus_if.o_gnt),     32'(e_gnt));
    check_val("done", 32'(bus_if.o_done),    32'(e_done));
    check_val("busy", 32'(bus_if.o_busy),    32'(m_owner >= 0));
    check_val("idx",  32'(bus_if.o_gnt_idx), 32'(m_idx));
  endtask

  // Drive this cycle's inputs and advance the model across the next edge.
  task automatic drive_step(input logic [N-1:0] req, input logic [N*W-1:0] dly);
    int pick;
    int d;
    bus_if.i_req       = req;
    bus_if.i_dly_ticks = dly;
    if (m_owner < 0) begin
      if (|req) begin
        pick = -1;
        for (int i = 0; i < N; i++) begin
          if (pick < 0 && req[(m_ptr + i) % N]) pick = (m_ptr + i) % N;
        end
        d       = int'(dly[pick*W +: W]);
        m_owner = pick;
        m_idx   = pick;
        m_rem   = (d == 0) ? 1 : d * DIV;
        $display("[TB] cyc %0d grant req %0d delay %0d", cyc + 1, pick, d);
      end
    end else if (m_rem == 0) begin
      $display("[TB] cyc %0d done req %0d", cyc, m_owner);
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (!req[m_owner]) begin
      $display("[TB] cyc %0d cancel req %0d", cyc, m_owner);
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_rem--;
    end
    cyc++;
  endtask

  initial begin
    logic [N-1:0]   nreq;
    logic [N*W-1:0] ndly;

    bus_if.i_req       = '0;
    bus_if.i_dly_ticks = '0;
    model_reset();

    // Outputs must be zero while reset is held.
    #1;
    check_val("rst_gnt",  32'(bus_if.o_gnt),     32'd0);
    check_val("rst_busy", 32'(bus_if.o_busy),    32'd0);
    check_val("rst_idx",  32'(bus_if.o_gnt_idx), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single D=3 request on requester 2: grant cycles 1..13, done at 13.
    ndly = '0;
    ndly[2*W +: W] = 8'd3;
    cyc = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      check_outputs();
      if (c >= 1) begin
        check_val("t1_gnt2",  32'(bus_if.o_gnt[2]),  32'(c <= 13));
        check_val("t1_done2", 32'(bus_if.o_done[2]), 32'(c == 13));
      end
      drive_step((c <= 13) ? 4'b0100 : 4'b0000, ndly);
    end

    // Randomized traffic with occasional cancels, delay changes and resets.
    nreq = '0;
    for (int it = 0; it < 4000; it++) begin
      @(negedge clk);
      check_outputs();
      if ($urandom_range(0, 249) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_gnt",  32'(bus_if.o_gnt),     32'd0);
        check_val("arst_done", 32'(bus_if.o_done),    32'd0);
        check_val("arst_busy", 32'(bus_if.o_busy),    32'd0);
        check_val("arst_idx",  32'(bus_if.o_gnt_idx), 32'd0);
        $display("[TB] cyc %0d reset", cyc);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc++;
        check_outputs();
      end
      nreq = bus_if.i_req;
      for (int k = 0; k < N; k++) begin
        if (!nreq[k]) begin
          if ($urandom_range(0, 3) == 0) nreq[k] = 1'b1;
        end else if (m_owner == k) begin
          if (m_rem == 0) begin
            if ($urandom_range(0, 1) == 0) nreq[k] = 1'b0;
          end else if ($urandom_range(0, 49) == 0) begin
            nreq[k] = 1'b0;
          end
        end
        if ($urandom_range(0, 9) == 0) begin
          ndly[k*W +: W] = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 12))
                                                        : 8'($urandom_range(0, 4));
        end
      end
      drive_step(nreq, ndly);
    end

    @(negedge clk);
    check_outputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
